// File: rtl/root_pifo_pkg.sv
// Shared constants, FSM state encoding and descriptor field helpers for the
// root PIFO output path. The field helpers are also used by the external bypass checker.
package root_pifo_pkg;

  localparam int unsigned PIFO_ROOT_WIDTH          = 32;
  localparam int unsigned ROOT_RANK_START_POS      = 12;
  localparam int unsigned ROOT_RANK_END_POS        = 30;
  localparam int unsigned ROOT_PIFO_INFO_VALID_POS = 31;
  localparam int unsigned ROOT_RANK_WIDTH          = ROOT_RANK_END_POS - ROOT_RANK_START_POS + 1;
  localparam int unsigned STARVE_LIMIT             = 4;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    CHECK   = 3'd1,
    EMIT    = 3'd2,
    PUSH    = 3'd3,
    POP_OUT = 3'd4,
    POP_ACK = 3'd5
  } state_t;

  function automatic logic [ROOT_RANK_WIDTH-1:0] get_rank(input logic [PIFO_ROOT_WIDTH-1:0] info);
    return info[ROOT_RANK_END_POS:ROOT_RANK_START_POS];
  endfunction

  function automatic logic get_valid(input logic [PIFO_ROOT_WIDTH-1:0] info);
    return info[ROOT_PIFO_INFO_VALID_POS];
  endfunction

endpackage

// File: rtl/root_pifo_starve_counter.sv
// Saturating count of bypass emits that overtook a valid calendar head;
// flags starvation once the count reaches LIMIT.
module root_pifo_starve_counter
  import root_pifo_pkg::*;
#(
  parameter int unsigned LIMIT = STARVE_LIMIT
) (
  input  logic clk,
  input  logic rst,
  input  logic inc,
  input  logic clr,
  output logic starved
);

  localparam int unsigned CW = $clog2(LIMIT + 1);
  localparam logic [CW-1:0] LIM = CW'(LIMIT);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc && (cnt < LIM)) begin
      cnt <= cnt + 1'b1;
    end
  end

  assign starved = (cnt >= LIM);

endmodule

// File: rtl/root_pifo_output_scheduler.sv
// Root PIFO output sequencer: arrivals go through the external bypass checker and
// are emitted or pushed; otherwise the calendar head is drained. Optional macro:
// ROOT_PIFO_STARVE_GUARD_EN forces a calendar drain after too many bypass emits.
module root_pifo_output_scheduler
  import root_pifo_pkg::*;
(
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       s_arr_valid,
  output logic                       s_arr_ready,
  input  logic [PIFO_ROOT_WIDTH-1:0] s_arr_info,
  output logic                       chk_valid,
  output logic [PIFO_ROOT_WIDTH-1:0] chk_info,
  output logic [PIFO_ROOT_WIDTH-1:0] chk_top,
  input  logic                       chk_result_valid,
  input  logic                       chk_bypass_en,
  input  logic [PIFO_ROOT_WIDTH-1:0] cal_top,
  output logic                       cal_push_valid,
  input  logic                       cal_push_ready,
  output logic [PIFO_ROOT_WIDTH-1:0] cal_push_info,
  output logic                       cal_pop_valid,
  input  logic                       cal_pop_ready,
  output logic                       m_valid,
  input  logic                       m_ready,
  output logic [PIFO_ROOT_WIDTH-1:0] m_info,
  output logic                       m_from_bypass,
  output logic                       drop_pulse,
  output state_t                     fsm_state
);

  // Handshakes: a transfer happens on any rising clk edge where valid && ready.
  // Every valid driven here decodes from the state register only, never from its ready.

  state_t                     state, next_state;
  logic [PIFO_ROOT_WIDTH-1:0] r_info, r_top;
  logic                       chk_sent;
  logic                       load_arr, load_top, drop, arr_ready;
  logic                       force_pop;

`ifdef ROOT_PIFO_STARVE_GUARD_EN
  logic starve_inc, starve_clr, starved;

  assign starve_inc = (state == EMIT) && m_ready && get_valid(r_top);
  assign starve_clr = (state == POP_ACK) && cal_pop_ready;

  root_pifo_starve_counter #(.LIMIT(STARVE_LIMIT)) u_starve (
    .clk     (clk),
    .rst     (rst),
    .inc     (starve_inc),
    .clr     (starve_clr),
    .starved (starved)
  );

  assign force_pop = starved && get_valid(cal_top);
`else
  assign force_pop = 1'b0;
`endif

  always_comb begin
    next_state = state;
    load_arr   = 1'b0;
    load_top   = 1'b0;
    drop       = 1'b0;
    arr_ready  = 1'b0;
    case (state)
      IDLE: begin
        arr_ready = !force_pop;
        if (force_pop) begin
          load_top   = 1'b1;
          next_state = POP_OUT;
        end else if (s_arr_valid) begin
          if (get_valid(s_arr_info)) begin
            load_arr   = 1'b1;
            load_top   = 1'b1;
            next_state = CHECK;
          end else begin
            drop = 1'b1;
          end
        end else if (get_valid(cal_top)) begin
          load_top   = 1'b1;
          next_state = POP_OUT;
        end
      end
      CHECK: begin
        if (chk_result_valid) next_state = chk_bypass_en ? EMIT : PUSH;
      end
      EMIT: begin
        if (m_ready) next_state = IDLE;
      end
      PUSH: begin
        if (cal_push_ready) next_state = IDLE;
      end
      POP_OUT: begin
        if (m_ready) next_state = POP_ACK;
      end
      POP_ACK: begin
        if (cal_pop_ready) next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      r_info     <= '0;
      r_top      <= '0;
      drop_pulse <= 1'b0;
      chk_sent   <= 1'b0;
    end else begin
      state      <= next_state;
      drop_pulse <= drop;
      // chk_valid is a single strobe: it is marked sent after the first CHECK cycle.
      chk_sent   <= (state == CHECK);
      if (load_arr) r_info <= s_arr_info;
      if (load_top) r_top <= cal_top;
    end
  end

  // IDLE is the reset state, so ready is masked to keep every output low during reset.
  assign s_arr_ready    = arr_ready && !rst;
  assign chk_valid      = (state == CHECK) && !chk_sent;
  assign chk_info       = r_info;
  assign chk_top        = r_top;
  assign cal_push_valid = (state == PUSH);
  assign cal_push_info  = r_info;
  assign cal_pop_valid  = (state == POP_ACK);
  assign m_valid        = (state == EMIT) || (state == POP_OUT);
  assign m_from_bypass  = (state == EMIT);
  assign m_info         = (state == EMIT)    ? r_info :
                          (state == POP_OUT) ? r_top  : '0;
  assign fsm_state      = state;

endmodule
